eeprom_ctrl: RTL and testbench

Sequencing controller for the 2K x 8 parallel EEPROM (11-bit address, 8-bit data, active-low CE/OE/WE).
- Accepts single-beat read/write requests on a valid/ready port.
- Generates glitch-free registered chip strobes with programmable setup, pulse and hold phases.
- Enforces write-recovery time before the next access.
- Sits between the control-unit/microcode loader and the EEPROM. Bidirectional data is split into out/oe/in; the top level assembles the tristate.

---
 rtl/eeprom_ctrl_pkg.sv | 23 ++
 rtl/eeprom_phase_timer.sv | 32 +++
 rtl/eeprom_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_eeprom_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_ctrl_pkg.sv
// eeprom_ctrl_pkg
// Shared widths, controller state encoding and the parameter clamp helper
// used by eeprom_ctrl and its phase timer.
package eeprom_ctrl_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RECOV  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Phase lengths below one cycle make no sense on the bus; treat them as one.
    function automatic int clamp1(input int x);
        return (x < 1) ? 1 : x;
    endfunction

endpackage

// File: rtl/eeprom_phase_timer.sv
// eeprom_phase_timer
// Loadable down-counter shared by every timed phase of the controller.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_load      - load i_load_val this cycle (takes priority over counting)
//   i_load_val  - terminal count minus one for the phase being entered
//   o_done      - counter has reached zero (last cycle of the phase)
module eeprom_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl
// Sequencer for a 2K x 8 parallel EEPROM with active-low CE/OE/WE.
// Takes single-beat read/write requests on a valid/ready port, drives
// registered chip strobes with programmable setup/pulse/hold phases and
// waits out the write-recovery time before responding.
// Optional build macro EEPROM_CTRL_VERIFY_EN: every write is followed by a
// read-back of the same address; rsp_rdata returns the read-back value and
// rsp_err flags a mismatch against the written data.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   req_valid/req_ready             - request handshake
//   req_we, req_addr, req_wdata     - request fields, latched on accept
//   rsp_valid, rsp_rdata, rsp_err   - one-cycle completion
//   busy                            - inverse of req_ready
//   ee_ce_n, ee_oe_n, ee_we_n       - chip strobes (registered)
//   ee_addr, ee_data_out, ee_data_oe, ee_data_in - address and split data bus
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ready for a request, chip deselected
// ST_SETUP   | CE low, address (and write data) settling before strobe
// ST_STROBE  | OE low for read / WE low for write
// ST_HOLD    | strobe released, CE/address/data held
// ST_RECOV   | write recovery, CE high, data bus released
// ST_RESP    | rsp_valid pulse, returns to IDLE
module eeprom_ctrl
    import eeprom_ctrl_pkg::*;
#(
    parameter int SETUP_CYC    = 1,
    parameter int PULSE_CYC    = 2,
    parameter int HOLD_CYC     = 1,
    parameter int WR_RECOV_CYC = 16,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              ee_ce_n,
    output logic              ee_oe_n,
    output logic              ee_we_n,
    output logic [ADDR_W-1:0] ee_addr,
    output logic [DATA_W-1:0] ee_data_out,
    output logic              ee_data_oe,
    input  logic [DATA_W-1:0] ee_data_in
);

    localparam logic [CNT_W-1:0] S_LD = CNT_W'(clamp1(SETUP_CYC) - 1);
    localparam logic [CNT_W-1:0] P_LD = CNT_W'(clamp1(PULSE_CYC) - 1);
    localparam logic [CNT_W-1:0] H_LD = CNT_W'(clamp1(HOLD_CYC) - 1);
    localparam logic [CNT_W-1:0] R_LD = CNT_W'(clamp1(WR_RECOV_CYC) - 1);

    state_t              r_state;
    logic                r_req_ready;
    logic                r_we;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_oe;

    logic                w_tmr_load;
    logic [CNT_W-1:0]    w_tmr_val;
    logic                w_tmr_done;
    logic                w_rd_phase;   // current SETUP/STROBE/HOLD pass uses read strobes

`ifdef EEPROM_CTRL_VERIFY_EN
    logic                r_verify;     // write has finished recovery, now reading back
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_err;

    assign w_rd_phase = !r_we || r_verify;
    assign rsp_err    = r_rsp_err;
`else
    assign w_rd_phase = !r_we;
    assign rsp_err    = 1'b0;
`endif

    // The counter is reloaded on the edge that leaves a timed phase, with the
    // length of whichever phase follows. In IDLE it is held at the setup
    // length so SETUP starts with the right count on the accept edge.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = S_LD;
            end
            ST_SETUP: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = P_LD;
            end
            ST_STROBE: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = H_LD;
            end
            ST_HOLD: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = R_LD;
            end
            ST_RECOV: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = S_LD;
            end
            default: begin
                w_tmr_load = 1'b0;
                w_tmr_val  = '0;
            end
        endcase
    end

    eeprom_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_addr      <= '0;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
`ifdef EEPROM_CTRL_VERIFY_EN
            r_verify    <= 1'b0;
            r_wdata     <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        if (req_we) begin
                            r_data_out <= req_wdata;
                        end
                        r_data_oe   <= req_we;
                        r_ce_n      <= 1'b0;
                        r_req_ready <= 1'b0;
`ifdef EEPROM_CTRL_VERIFY_EN
                        r_verify    <= 1'b0;
                        r_wdata     <= req_wdata;
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_done) begin
                        if (w_rd_phase) begin
                            r_oe_n <= 1'b0;
                        end else begin
                            r_we_n <= 1'b0;
                        end
                        r_state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (w_tmr_done) begin
                        r_oe_n <= 1'b1;
                        r_we_n <= 1'b1;
                        if (w_rd_phase) begin
                            r_rsp_rdata <= ee_data_in;
                        end
`ifdef EEPROM_CTRL_VERIFY_EN
                        if (r_verify) begin
                            r_rsp_err <= (ee_data_in != r_wdata);
                        end
`endif
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_tmr_done) begin
                        r_ce_n    <= 1'b1;
                        r_data_oe <= 1'b0;
                        if (w_rd_phase) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_state     <= ST_RECOV;
                        end
                    end
                end
                ST_RECOV: begin
                    if (w_tmr_done) begin
`ifdef EEPROM_CTRL_VERIFY_EN
                        r_verify <= 1'b1;
                        r_ce_n   <= 1'b0;
                        r_state  <= ST_SETUP;
`else
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
`endif
                    end
                end
                ST_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign busy        = ~r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign ee_ce_n     = r_ce_n;
    assign ee_oe_n     = r_oe_n;
    assign ee_we_n     = r_we_n;
    assign ee_addr     = r_addr;
    assign ee_data_out = r_data_out;
    assign ee_data_oe  = r_data_oe;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// tb_eeprom_ctrl
// Two controller instances: u_dut0 with default timing for the directed
// sequence, u_dut1 with SETUP_CYC=0/PULSE_CYC=3/HOLD_CYC=2 for the random
// protocol run. A shared behavioural EEPROM array serves both; a separate
// reference array holds the values the bench expects to read back.
module tb_eeprom_ctrl;

`ifdef EEPROM_CTRL_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    typedef struct {
        int         dut;
        int         cyc;
        logic [7:0] rdata;
        logic       err;
        int         oe_lo;
        int         we_lo;
        int         doe_hi;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req_we;
    logic [10:0] req_addr;
    logic [7:0]  req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata [2];
    logic [1:0]  rsp_err;
    logic [1:0]  busy;
    logic [1:0]  ee_ce_n;
    logic [1:0]  ee_oe_n;
    logic [1:0]  ee_we_n;
    logic [10:0] ee_addr [2];
    logic [7:0]  ee_data_out [2];
    logic [1:0]  ee_data_oe;
    logic [7:0]  ee_data_in [2];

    logic [7:0]  mem [2048];
    logic [7:0]  ref_mem [2048];
    logic        stuck;
    logic [7:0]  rd_mask;
    logic [7:0]  last_rd [2];
    exp_t        sb [$];
    int          cyc;
    int          checks;
    int          failures;
    int          oe_cnt [2];
    int          we_cnt [2];
    int          doe_cnt [2];
    logic [1:0]  prev_we_n;
    logic [1:0]  prev_ce_n;
    logic [10:0] prev_addr [2];

    assign rd_mask = stuck ? 8'hFE : 8'hFF;
    assign ee_data_in[0] = (!ee_oe_n[0] && !ee_ce_n[0]) ? (mem[ee_addr[0]] & rd_mask) : 8'h00;
    assign ee_data_in[1] = (!ee_oe_n[1] && !ee_ce_n[1]) ? (mem[ee_addr[1]] & rd_mask) : 8'h00;

    eeprom_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0]), .ee_ce_n(ee_ce_n[0]), .ee_oe_n(ee_oe_n[0]), .ee_we_n(ee_we_n[0]),
        .ee_addr(ee_addr[0]), .ee_data_out(ee_data_out[0]), .ee_data_oe(ee_data_oe[0]),
        .ee_data_in(ee_data_in[0])
    );

    eeprom_ctrl #(.SETUP_CYC(0), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1]), .ee_ce_n(ee_ce_n[1]), .ee_oe_n(ee_oe_n[1]), .ee_we_n(ee_we_n[1]),
        .ee_addr(ee_addr[1]), .ee_data_out(ee_data_out[1]), .ee_data_oe(ee_data_oe[1]),
        .ee_data_in(ee_data_in[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected timing: dut0 S=1 P=2 H=1, dut1 S=0->1 P=3 H=2; both R=16.
    function automatic int ph_sum(input int d);
        return (d == 0) ? 4 : 6;
    endfunction

    function automatic int pulse(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int lat_of(input int d, input bit we);
        return 1 + ph_sum(d) + (we ? (16 + (VER ? ph_sum(d) : 0)) : 0);
    endfunction

    // Monitor: EEPROM model write-on-WE-rise, bus invariants, strobe pulse
    // counting and scoreboard pop on every response.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (prev_we_n[d] == 1'b0 && ee_we_n[d] && !ee_ce_n[d] && ee_data_oe[d])
                mem[ee_addr[d]] = ee_data_out[d];
            chk("inv_oe_we", 32'(!ee_oe_n[d] && !ee_we_n[d]), 0);
            chk("inv_doe_oe", 32'(ee_data_oe[d] && !ee_oe_n[d]), 0);
            chk("inv_strobe_ce", 32'((!ee_oe_n[d] || !ee_we_n[d]) && ee_ce_n[d]), 0);
            if (!prev_ce_n[d] && !ee_ce_n[d])
                chk("inv_addr_stable", 32'(ee_addr[d]), 32'(prev_addr[d]));
            if (!rst_n) begin
                oe_cnt[d] = 0; we_cnt[d] = 0; doe_cnt[d] = 0;
            end else begin
                if (!ee_oe_n[d]) oe_cnt[d]++;
                if (!ee_we_n[d]) we_cnt[d]++;
                if (ee_data_oe[d]) doe_cnt[d]++;
            end
            if (rsp_valid[d]) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid[d]), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_dut", d, e.dut);
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_rdata", 32'(rsp_rdata[d]), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
                    chk("oe_low_cycles", oe_cnt[d], e.oe_lo);
                    chk("we_low_cycles", we_cnt[d], e.we_lo);
                    chk("data_oe_cycles", doe_cnt[d], e.doe_hi);
                end
                oe_cnt[d] = 0; we_cnt[d] = 0; doe_cnt[d] = 0;
            end
            prev_we_n[d] = ee_we_n[d];
            prev_ce_n[d] = ee_ce_n[d];
            prev_addr[d] = ee_addr[d];
        end
    end

    // Drive one request on dut d; acc returns the accept edge, waited the
    // number of cycles req_ready was seen low first. With hold=1 req_valid
    // stays high on return so the next call forms a back-to-back pair.
    task automatic issue(input int d, input bit we, input logic [10:0] a,
                         input logic [7:0] wd, input bit hold, input bit expect_rsp,
                         output int acc, output int waited);
        exp_t e;
        int n;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(req_ready[d]), 1);
        acc = cyc + 1;
        waited = n;
        if (expect_rsp) begin
            e.dut    = d;
            e.cyc    = acc + lat_of(d, we) - 1;
            e.oe_lo  = (!we || VER) ? pulse(d) : 0;
            e.we_lo  = we ? pulse(d) : 0;
            e.doe_hi = we ? ph_sum(d) : 0;
            if (we) begin
                e.rdata = VER ? (wd & rd_mask) : last_rd[d];
                e.err   = VER && ((wd & rd_mask) != wd);
                ref_mem[a] = wd;
            end else begin
                e.rdata = ref_mem[a] & rd_mask;
                e.err   = 1'b0;
            end
            last_rd[d] = e.rdata;
            sb.push_back(e);
        end
        @(posedge clk);
        if (!hold) begin
            #1 req_valid[d] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int a1, a2, w1, w2;
        checks = 0; failures = 0; cyc = 0;
        stuck = 1'b0;
        req_valid = 2'b00; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        prev_we_n = 2'b11; prev_ce_n = 2'b11;
        prev_addr[0] = '0; prev_addr[1] = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        for (int i = 0; i < 2; i++) begin
            oe_cnt[i] = 0; we_cnt[i] = 0; doe_cnt[i] = 0;
        end
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[11'h123] = 8'hA5;
        ref_mem[11'h123] = 8'hA5;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(ee_ce_n[0]), 1);
        chk("rst_oe_n", 32'(ee_oe_n[0]), 1);
        chk("rst_we_n", 32'(ee_we_n[0]), 1);
        chk("rst_data_oe", 32'(ee_data_oe[0]), 0);
        chk("rst_addr", 32'(ee_addr[0]), 0);
        chk("rst_data_out", 32'(ee_data_out[0]), 0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata[0]), 0);
        chk("rst_rsp_err", 32'(rsp_err[0]), 0);
        chk("rst_req_ready", 32'(req_ready[0]), 1);
        chk("rst_busy", 32'(busy[0]), 0);
        rst_n = 1'b1;

        // Default-timing read and write, then read back the written address.
        issue(0, 1'b0, 11'h123, 8'h00, 1'b0, 1'b1, a1, w1);
        issue(0, 1'b1, 11'h7FF, 8'h3C, 1'b0, 1'b1, a1, w1);
        issue(0, 1'b0, 11'h7FF, 8'h00, 1'b0, 1'b1, a1, w1);

        // Back-to-back with req_valid held high across both requests.
        issue(0, 1'b1, 11'h000, 8'h11, 1'b1, 1'b1, a1, w1);
        issue(0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b1, a2, w2);
        chk("b2b_ready_low_cycles", w2, lat_of(0, 1'b1));
        chk("b2b_accept_gap", a2 - a1, lat_of(0, 1'b1) + 1);
        drain();

        // Reset in the middle of a write strobe: no response, no memory update.
        issue(0, 1'b1, 11'h123, 8'h5A, 1'b0, 1'b0, a1, w1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_low_before_reset", 32'(ee_we_n[0]), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we_n_async", 32'(ee_we_n[0]), 1);
        chk("abort_ce_n_async", 32'(ee_ce_n[0]), 1);
        chk("abort_data_oe_async", 32'(ee_data_oe[0]), 0);
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_ready_after_reset", 32'(req_ready[0]), 1);
        issue(0, 1'b0, 11'h123, 8'h00, 1'b0, 1'b1, a1, w1);
        drain();

`ifdef EEPROM_CTRL_VERIFY_EN
        // Read path with bit 0 stuck low: write-verify flags the mismatch.
        stuck = 1'b1;
        issue(0, 1'b1, 11'h200, 8'h01, 1'b0, 1'b1, a1, w1);
        issue(0, 1'b1, 11'h201, 8'h02, 1'b0, 1'b1, a1, w1);
        drain();
        stuck = 1'b0;
`endif

        // Random protocol run on the clamped-timing instance.
        for (int i = 0; i < 1000; i++) begin
            issue(1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 1'b0, 1'b1, a1, w1);
        end
        drain();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
